reg_file_param: RTL and testbench

- Parametrised successor to the single-write, dual-read CPU register file.
- Width, depth and an optional hardwired zero register are configurable.
- Adds a dedicated write address, write-to-read bypass, and a sequential bulk-clear engine.
- Sits between decode (read ports) and writeback (write port) in the KGP-RISC datapath.

---
 rtl/reg_file_param.sv | 95 +++++++++
 tb/tb_reg_file_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised dual-read, single-write register file with write-to-read bypass
// and a sequential bulk-clear engine that sweeps one register per clock.
module reg_file_param #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [WIDTH-1:0]  rd_data1,
   output logic [WIDTH-1:0]  rd_data2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_done
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              clr_done_q, clr_done_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [WIDTH-1:0]  mem_d [DEPTH];
   logic              wr_acc;
   logic              wr_commit;

   // Writes only land while idle; the bypass follows the same acceptance rule.
   assign wr_acc    = wr_en && (state_q == IDLE);
   assign wr_commit = wr_acc && !(ZERO_REG && (wr_addr == '0));

   assign rd_data1 = (ZERO_REG && (rd_addr1 == '0))    ? '0      :
                     (wr_acc && (wr_addr == rd_addr1)) ? wr_data :
                                                         mem_q[rd_addr1];
   assign rd_data2 = (ZERO_REG && (rd_addr2 == '0))    ? '0      :
                     (wr_acc && (wr_addr == rd_addr2)) ? wr_data :
                                                         mem_q[rd_addr2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // clr_req is ignored during CLEAR, so a held request cannot extend a sweep.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (clr_req) state_d = CLEAR;
         CLEAR:   if (cnt_q == ADDR_W'(DEPTH-1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == CLEAR);
   end

   always_comb begin
      cnt_d      = cnt_q;
      clr_done_d = 1'b0;
      mem_d      = mem_q;
      if (state_q == IDLE) begin
         if (wr_commit) mem_d[wr_addr] = wr_data;
         if (clr_req) cnt_d = '0;
      end else begin
         mem_d[cnt_q] = '0;
         cnt_d        = cnt_q + ADDR_W'(1);
         if (cnt_q == ADDR_W'(DEPTH-1)) clr_done_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         clr_done_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         cnt_q      <= cnt_d;
         clr_done_q <= clr_done_d;
         mem_q      <= mem_d;
      end
   end

   assign clr_done = clr_done_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: a ZERO_REG=0 and a ZERO_REG=1 instance share stimulus
// and are compared against constant tables and an array-based reference model.
module tb_reg_file_param;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ra1, ra2, wa;
   logic [31:0] wd;
   logic        wr_en, clr_req;
   logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
   logic        busy0, done0, busy1, done1;

   int checks = 0;
   int errors = 0;

   logic [31:0] m0 [32];
   logic [31:0] m1 [32];
   bit          m_busy;
   int          m_cnt;
   bit          m_done;

   always #5 clk = ~clk;

   reg_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut0 (
      .clk(clk), .reset(reset), .rd_addr1(ra1), .rd_addr2(ra2),
      .rd_data1(rd1_0), .rd_data2(rd2_0), .wr_en(wr_en), .wr_addr(wa),
      .wr_data(wd), .clr_req(clr_req), .busy(busy0), .clr_done(done0));

   reg_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut1 (
      .clk(clk), .reset(reset), .rd_addr1(ra1), .rd_addr2(ra2),
      .rd_data1(rd1_1), .rd_data2(rd2_1), .wr_en(wr_en), .wr_addr(wa),
      .wr_data(wd), .clr_req(clr_req), .busy(busy1), .clr_done(done1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m0[i] = '0;
         m1[i] = '0;
      end
      m_busy = 0;
      m_cnt  = 0;
      m_done = 0;
   endtask

   function automatic logic [31:0] exp_rd(input bit z, input logic [4:0] a);
      if (z && a == 5'd0) return 32'd0;
      if (wr_en && !m_busy && wa == a) return wd;
      return z ? m1[a] : m0[a];
   endfunction

   // One clock edge of the reference: write in idle, start sweep, or clear next register.
   task automatic model_edge();
      bit done_n = 0;
      if (!m_busy) begin
         if (wr_en) begin
            m0[wa] = wd;
            if (wa != 5'd0) m1[wa] = wd;
         end
         if (clr_req) begin
            m_busy = 1;
            m_cnt  = 0;
         end
      end else begin
         m0[m_cnt] = '0;
         m1[m_cnt] = '0;
         m_cnt++;
         if (m_cnt == 32) begin
            m_busy = 0;
            m_cnt  = 0;
            done_n = 1;
         end
      end
      m_done = done_n;
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_edge();
      #1;
      check("busy0", {31'd0, busy0}, {31'd0, m_busy});
      check("done0", {31'd0, done0}, {31'd0, m_done});
      check("busy1", {31'd0, busy1}, {31'd0, m_busy});
      check("done1", {31'd0, done1}, {31'd0, m_done});
   endtask

   task automatic check_reads();
      #1;
      check("rd1_z0", rd1_0, exp_rd(0, ra1));
      check("rd2_z0", rd2_0, exp_rd(0, ra2));
      check("rd1_z1", rd1_1, exp_rd(1, ra1));
      check("rd2_z1", rd2_1, exp_rd(1, ra2));
   endtask

   task automatic check_all_zero(input string name);
      for (int i = 0; i < 32; i++) begin
         ra1 = 5'(i);
         ra2 = 5'(31 - i);
         #1;
         check({name, "_p1_z0"}, rd1_0, 32'd0);
         check({name, "_p2_z0"}, rd2_0, 32'd0);
         check({name, "_p1_z1"}, rd1_1, 32'd0);
      end
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] x1;
      logic [31:0] x2;
      logic [31:0] y1;
   } vec_t;

   vec_t vecs [8];
   int   busy_cyc, done_cyc;

   initial begin
      vecs[0] = '{1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
      vecs[2] = '{1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3, 32'h12345678, 32'h12345678, 32'h12345678};
      vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd7, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
      vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd3, 32'hFFFFFFFF, 32'h12345678, 32'h0};
      vecs[5] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
      vecs[6] = '{1'b1, 5'd7, 32'h0,        5'd7, 5'd3, 32'h0,        32'h12345678, 32'h0};
      vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 32'h0,        32'h0,        32'h0};

      reset = 1'b0; wr_en = 0; clr_req = 0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy0}, 32'd0);
      check("rst_done", {31'd0, done0}, 32'd0);
      reset = 1'b1;
      check_all_zero("rst_rd");

      // Table-driven basic write, read, bypass and zero-register vectors
      for (int i = 0; i < 8; i++) begin
         wr_en = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
         ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
         #1;
         check($sformatf("vec%0d_rd1", i), rd1_0, vecs[i].x1);
         check($sformatf("vec%0d_rd2", i), rd2_0, vecs[i].x2);
         check($sformatf("vec%0d_z_rd1", i), rd1_1, vecs[i].y1);
         tick();
         wr_en = 0;
      end

      // Fill r0..r31 with index+1, then sweep
      for (int i = 0; i < 32; i++) begin
         wr_en = 1; wa = 5'(i); wd = 32'(i + 1);
         tick();
      end
      wr_en = 0;
      clr_req = 1;
      tick();
      clr_req = 0;
      busy_cyc = 0; done_cyc = 0;
      for (int k = 0; k < 80; k++) begin
         if (busy0) busy_cyc++;
         if (done0) done_cyc++;
         if (k == 10) begin
            ra1 = 5'd5; ra2 = 5'd20;
            #1;
            check("sweep_r5", rd1_0, 32'd0);
            check("sweep_r20", rd2_0, 32'd21);
         end
         if (k == 5) begin
            wr_en = 1; wa = 5'd31; wd = 32'hAAAA5555; ra1 = 5'd31;
            #1;
            check("sweep_nobypass", rd1_0, 32'd32);
         end
         if (k == 15) clr_req = 1;
         tick();
         wr_en = 0; clr_req = 0;
      end
      check("busy_cycles", busy_cyc, 32);
      check("done_pulses", done_cyc, 1);
      check_all_zero("post_clr");

      // Reset asserted between edges mid-sweep
      for (int i = 1; i < 32; i += 3) begin
         wr_en = 1; wa = 5'(i); wd = $urandom;
         tick();
      end
      wr_en = 0; clr_req = 1;
      tick();
      clr_req = 0;
      repeat (12) tick();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check("abort_busy0", {31'd0, busy0}, 32'd0);
      check("abort_busy1", {31'd0, busy1}, 32'd0);
      check_all_zero("abort_rd");
      repeat (2) tick();
      reset = 1'b1;
      done_cyc = 0;
      for (int k = 0; k < 40; k++) begin
         if (done0 || done1) done_cyc++;
         tick();
      end
      check("abort_no_done", done_cyc, 0);
      wr_en = 1; wa = 5'd9; wd = 32'hCAFEF00D;
      tick();
      wr_en = 0; ra1 = 5'd9; ra2 = 5'd9;
      #1;
      check("post_abort_wr", rd1_0, 32'hCAFEF00D);
      check("post_abort_wr_z", rd2_1, 32'hCAFEF00D);

      // Randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wa      = 5'($urandom_range(0, 31));
         wd      = $urandom;
         ra1     = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         ra2     = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         if ($urandom_range(0, 9) == 0) ra1 = 5'd0;
         clr_req = ($urandom_range(0, 59) == 0);
         check_reads();
         tick();
      end
      wr_en = 0; clr_req = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
